// File: rtl/axi_err_slv_if.sv
// AXI4 bus bundle used by the error slave: full AW/W/B/AR/R channel set with
// Slave and Master views.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    localparam int unsigned StrbWidth = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [StrbWidth-1:0]      w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );
endinterface

// File: rtl/axi_err_slv.sv
// AXI4 error slave: accepts every AW/AR, drains W data and answers with RespCode.
// Optional error counter / address capture / irq enabled by AXI_ERR_SLV_CNT_EN.

// Handshake rule on every channel: a transfer happens on the rising clk edge where
// valid && ready; a source never withdraws or changes a raised valid before that edge.
module axi_err_slv_fifo #(
    parameter int unsigned Width = 4,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata,
    output logic             empty,
    output logic             ready
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  cnt;
    logic [CntW-1:0]  cnt_next;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CntW'(Depth));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_comb begin
        cnt_next = cnt;
        if (do_push && !do_pop) begin
            cnt_next = cnt + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_next = cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ready  <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            ready <= (cnt_next != CntW'(Depth));
            if (do_push) begin
                wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end
endmodule

module axi_err_slv #(
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned AxiIdWidth   = 4,
    parameter int unsigned AxiUserWidth = 1,
    parameter logic [1:0]  RespCode     = 2'b10,
    parameter logic [63:0] RespData     = 64'hdeadbeef,
    parameter int unsigned MaxTrans     = 4,
    parameter int unsigned CntWidth     = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    AXI_BUS.Slave                   slave,
    output logic [CntWidth-1:0]     err_cnt_o,
    output logic [AxiAddrWidth-1:0] err_addr_o,
    output logic                    err_irq_o
);
    localparam logic [AxiDataWidth-1:0] RespDataW = AxiDataWidth'(RespData);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    typedef struct packed {
        w_state_e w_state;
        r_state_e r_state;
    } dbg_state_t;

    w_state_e              w_state;
    r_state_e              r_state;
    dbg_state_t            dbg_state;

    logic                  aw_hs;
    logic                  ar_hs;
    logic                  aw_pop;
    logic                  ar_pop;
    logic                  aw_empty;
    logic                  ar_empty;
    logic                  aw_fifo_ready;
    logic                  ar_fifo_ready;
    logic [AxiIdWidth-1:0] aw_head;
    logic [AxiIdWidth+7:0] ar_head;

    logic                  w_ready_q;
    logic                  b_valid_q;
    logic [AxiIdWidth-1:0] b_id_q;
    logic                  r_valid_q;
    logic                  r_last_q;
    logic [AxiIdWidth-1:0] r_id_q;
    logic [7:0]            beat_cnt;

    assign aw_hs  = slave.aw_valid && aw_fifo_ready;
    assign ar_hs  = slave.ar_valid && ar_fifo_ready;
    assign aw_pop = (w_state == W_RESP) && slave.b_ready;
    assign ar_pop = (r_state == R_DATA) && slave.r_ready && r_last_q;

    assign dbg_state = '{w_state: w_state, r_state: r_state};

    axi_err_slv_fifo #(
        .Width (AxiIdWidth),
        .Depth (MaxTrans)
    ) i_aw_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (aw_hs),
        .pop   (aw_pop),
        .wdata (slave.aw_id),
        .rdata (aw_head),
        .empty (aw_empty),
        .ready (aw_fifo_ready)
    );

    axi_err_slv_fifo #(
        .Width (AxiIdWidth + 8),
        .Depth (MaxTrans)
    ) i_ar_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (ar_hs),
        .pop   (ar_pop),
        .wdata ({slave.ar_id, slave.ar_len}),
        .rdata (ar_head),
        .empty (ar_empty),
        .ready (ar_fifo_ready)
    );

    // Write path: W beats are only accepted once their AW sits at the FIFO head.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state   <= W_IDLE;
            w_ready_q <= 1'b0;
            b_valid_q <= 1'b0;
            b_id_q    <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (!aw_empty) begin
                        w_state   <= W_DATA;
                        w_ready_q <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (slave.w_valid && slave.w_last) begin
                        w_state   <= W_RESP;
                        w_ready_q <= 1'b0;
                        b_valid_q <= 1'b1;
                        b_id_q    <= aw_head;
                    end
                end
                W_RESP: begin
                    if (slave.b_ready) begin
                        w_state   <= W_IDLE;
                        b_valid_q <= 1'b0;
                    end
                end
                default: begin
                    w_state   <= W_IDLE;
                    w_ready_q <= 1'b0;
                    b_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Read path: beat_cnt holds the beats still to follow the one on the bus.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= R_IDLE;
            r_valid_q <= 1'b0;
            r_last_q  <= 1'b0;
            r_id_q    <= '0;
            beat_cnt  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (!ar_empty) begin
                        r_state   <= R_DATA;
                        r_valid_q <= 1'b1;
                        r_id_q    <= ar_head[AxiIdWidth+7:8];
                        beat_cnt  <= ar_head[7:0];
                        r_last_q  <= (ar_head[7:0] == 8'd0);
                    end
                end
                R_DATA: begin
                    if (slave.r_ready) begin
                        if (r_last_q) begin
                            r_state   <= R_IDLE;
                            r_valid_q <= 1'b0;
                            r_last_q  <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt - 1'b1;
                            r_last_q <= (beat_cnt == 8'd1);
                        end
                    end
                end
                default: begin
                    r_state   <= R_IDLE;
                    r_valid_q <= 1'b0;
                    r_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign slave.aw_ready = aw_fifo_ready;
    assign slave.ar_ready = ar_fifo_ready;
    assign slave.w_ready  = w_ready_q;
    assign slave.b_valid  = b_valid_q;
    assign slave.b_id     = b_id_q;
    assign slave.b_resp   = RespCode;
    assign slave.b_user   = '0;
    assign slave.r_valid  = r_valid_q;
    assign slave.r_id     = r_id_q;
    assign slave.r_data   = RespDataW;
    assign slave.r_resp   = RespCode;
    assign slave.r_last   = r_last_q;
    assign slave.r_user   = '0;

`ifdef AXI_ERR_SLV_CNT_EN
    logic                b_done;
    logic                r_done;
    logic [1:0]          inc;
    logic [CntWidth:0]   cnt_sum;
    logic [CntWidth-1:0] err_cnt_q;

    assign b_done  = b_valid_q && slave.b_ready;
    assign r_done  = r_valid_q && slave.r_ready && r_last_q;
    assign inc     = {1'b0, b_done} + {1'b0, r_done};
    assign cnt_sum = {1'b0, err_cnt_q} + (CntWidth + 1)'(inc);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_q  <= '0;
            err_addr_o <= '0;
            err_irq_o  <= 1'b0;
        end else begin
            err_cnt_q <= cnt_sum[CntWidth] ? '1 : cnt_sum[CntWidth-1:0];
            err_irq_o <= b_done || r_done;
            if (ar_hs) begin
                err_addr_o <= slave.ar_addr;
            end else if (aw_hs) begin
                err_addr_o <= slave.aw_addr;
            end
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    logic unused_addr;
    assign unused_addr = ^{slave.aw_addr, slave.ar_addr};

    assign err_cnt_o  = '0;
    assign err_addr_o = '0;
    assign err_irq_o  = 1'b0;
`endif

    // Request attributes and write payload carry no meaning for an error responder.
    logic unused_fields;
    assign unused_fields = ^{slave.aw_len, slave.aw_size, slave.aw_burst, slave.aw_lock,
                             slave.aw_cache, slave.aw_prot, slave.aw_qos, slave.aw_region,
                             slave.aw_user, slave.w_data, slave.w_strb, slave.w_user,
                             slave.ar_size, slave.ar_burst, slave.ar_lock, slave.ar_cache,
                             slave.ar_prot, slave.ar_qos, slave.ar_region, slave.ar_user,
                             w_ready_q, dbg_state};
endmodule

// File: tb/tb_axi_err_slv.sv
// Directed bench for axi_err_slv (MaxTrans=2, CntWidth=2); counter checks follow
// AXI_ERR_SLV_CNT_EN.
module tb_axi_err_slv;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int UW = 1;
    localparam int CW = 2;
    localparam int MT = 2;
    localparam int CntMax = (1 << CW) - 1;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    AXI_BUS #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .AXI_ID_WIDTH   (IW),
        .AXI_USER_WIDTH (UW)
    ) bus ();

    logic [CW-1:0] err_cnt;
    logic [AW-1:0] err_addr;
    logic          err_irq;

    axi_err_slv #(
        .AxiAddrWidth (AW),
        .AxiDataWidth (DW),
        .AxiIdWidth   (IW),
        .AxiUserWidth (UW),
        .MaxTrans     (MT),
        .CntWidth     (CW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .slave      (bus),
        .err_cnt_o  (err_cnt),
        .err_addr_o (err_addr),
        .err_irq_o  (err_irq)
    );

    // scoreboard
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [IW-1:0] exp_q[$];
    logic [IW-1:0] exp_r_q[$];
    int            exp_cnt  = 0;
    logic [AW-1:0] exp_addr = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void note_done();
`ifdef AXI_ERR_SLV_CNT_EN
        if (exp_cnt < CntMax) exp_cnt++;
`endif
    endfunction

    function automatic logic [63:0] cnt_v();
`ifdef AXI_ERR_SLV_CNT_EN
        return 64'(exp_cnt);
`else
        return 64'd0;
`endif
    endfunction

    function automatic logic [63:0] addr_v();
`ifdef AXI_ERR_SLV_CNT_EN
        return exp_addr;
`else
        return 64'd0;
`endif
    endfunction

    function automatic logic [63:0] irq_v();
`ifdef AXI_ERR_SLV_CNT_EN
        return 64'd1;
`else
        return 64'd0;
`endif
    endfunction

    // driver tasks (all entered and left on a falling edge)
    task automatic send_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr);
        bus.aw_id    = id;
        bus.aw_addr  = addr;
        bus.aw_valid = 1'b1;
        for (int i = 0; i < 50 && bus.aw_ready !== 1'b1; i++) @(negedge clk);
        check("aw_accept", bus.aw_ready, 1);
        @(negedge clk);
        bus.aw_valid = 1'b0;
        exp_q.push_back(id);
        exp_addr = addr;
    endtask

    task automatic send_ar(input logic [IW-1:0] id, input logic [7:0] len, input logic [AW-1:0] addr);
        bus.ar_id    = id;
        bus.ar_len   = len;
        bus.ar_addr  = addr;
        bus.ar_valid = 1'b1;
        for (int i = 0; i < 50 && bus.ar_ready !== 1'b1; i++) @(negedge clk);
        check("ar_accept", bus.ar_ready, 1);
        @(negedge clk);
        bus.ar_valid = 1'b0;
        exp_r_q.push_back(id);
        exp_addr = addr;
    endtask

    task automatic send_w();
        bus.w_data  = {$urandom, $urandom};
        bus.w_last  = 1'b1;
        bus.w_valid = 1'b1;
        for (int i = 0; i < 50 && bus.w_ready !== 1'b1; i++) @(negedge clk);
        check("w_accept", bus.w_ready, 1);
        @(negedge clk);
        bus.w_valid = 1'b0;
    endtask

    task automatic collect_b();
        logic [IW-1:0] id;
        for (int i = 0; i < 50 && bus.b_valid !== 1'b1; i++) @(negedge clk);
        check("b_valid", bus.b_valid, 1);
        id = exp_q.pop_front();
        check("b_id", bus.b_id, id);
        check("b_resp", bus.b_resp, 2'b10);
        bus.b_ready = 1'b1;
        @(negedge clk);
        bus.b_ready = 1'b0;
        note_done();
    endtask

    task automatic collect_r(input int nbeats, input int len);
        bus.r_ready = 1'b1;
        for (int b = 0; b < nbeats; b++) begin
            for (int i = 0; i < 50 && bus.r_valid !== 1'b1; i++) @(negedge clk);
            check("r_valid", bus.r_valid, 1);
            check("r_id", bus.r_id, exp_r_q[0]);
            check("r_data", bus.r_data, 64'hdeadbeef);
            check("r_last", bus.r_last, (b == len) ? 1 : 0);
            @(negedge clk);
            if (b == len) begin
                void'(exp_r_q.pop_front());
                note_done();
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0; bus.aw_burst = '0;
        bus.aw_lock = '0; bus.aw_cache = '0; bus.aw_prot = '0; bus.aw_qos = '0;
        bus.aw_region = '0; bus.aw_user = '0; bus.aw_valid = 1'b0;
        bus.w_data = '0; bus.w_strb = '1; bus.w_last = 1'b0; bus.w_user = '0; bus.w_valid = 1'b0;
        bus.b_ready = 1'b0;
        bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = '0; bus.ar_burst = '0;
        bus.ar_lock = '0; bus.ar_cache = '0; bus.ar_prot = '0; bus.ar_qos = '0;
        bus.ar_region = '0; bus.ar_user = '0; bus.ar_valid = 1'b0;
        bus.r_ready = 1'b0;

        // reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_aw_ready", bus.aw_ready, 0);
        check("rst_ar_ready", bus.ar_ready, 0);
        check("rst_w_ready", bus.w_ready, 0);
        check("rst_b_valid", bus.b_valid, 0);
        check("rst_r_valid", bus.r_valid, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_err_addr", err_addr, 0);
        check("rst_err_irq", err_irq, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_aw_ready", bus.aw_ready, 1);
        check("idle_ar_ready", bus.ar_ready, 1);

        // single write: B one cycle after the W handshake
        send_aw(4'd3, 64'h1000);
        send_w();
        check("b_latency", bus.b_valid, 1);
        collect_b();
        check("wr1_b_drop", bus.b_valid, 0);
        check("wr1_err_cnt", err_cnt, cnt_v());
        check("wr1_err_addr", err_addr, addr_v());
        check("wr1_err_irq", err_irq, irq_v());
        @(negedge clk);
        check("wr1_irq_pulse", err_irq, 0);

        // 8-beat read burst
        bus.r_ready = 1'b1;
        send_ar(4'd5, 8'd7, 64'h2000);
        check("r_not_early", bus.r_valid, 0);
        collect_r(8, 7);
        check("rd_done_valid", bus.r_valid, 0);
        check("rd_err_cnt", err_cnt, cnt_v());
        check("rd_err_addr", err_addr, addr_v());

        // backpressure: third AW stalls until the first write completes
        send_aw(4'd1, 64'h3000);
        send_aw(4'd2, 64'h3008);
        bus.aw_id    = 4'd6;
        bus.aw_addr  = 64'h3010;
        bus.aw_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("aw_stall", bus.aw_ready, 0);
        send_w();
        collect_b();
        for (int i = 0; i < 50 && bus.aw_ready !== 1'b1; i++) @(negedge clk);
        check("aw_third_accept", bus.aw_ready, 1);
        @(negedge clk);
        bus.aw_valid = 1'b0;
        exp_q.push_back(4'd6);
        exp_addr = 64'h3010;
        send_w();
        collect_b();
        send_w();
        collect_b();
        check("bp_err_cnt_sat", err_cnt, cnt_v());
        check("bp_err_addr", err_addr, addr_v());

        // W presented five cycles before its AW
        bus.w_data  = {$urandom, $urandom};
        bus.w_last  = 1'b1;
        bus.w_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("w_stall", bus.w_ready, 0);
        end
        send_aw(4'd9, 64'h4000);
        for (int i = 0; i < 50 && bus.w_ready !== 1'b1; i++) @(negedge clk);
        check("w_early_accept", bus.w_ready, 1);
        @(negedge clk);
        bus.w_valid = 1'b0;
        collect_b();
        check("wearly_err_cnt", err_cnt, cnt_v());
        check("wearly_err_addr", err_addr, addr_v());

        // reset in the middle of a 16-beat burst
        send_ar(4'd7, 8'd15, 64'h5000);
        collect_r(4, 15);
        check("mid_r_valid", bus.r_valid, 1);
        #2 rst = 1'b1;
        #1 check("r_async_drop", bus.r_valid, 0);
        check("rst_mid_err_cnt", err_cnt, 0);
        check("rst_mid_err_addr", err_addr, 0);
        exp_r_q.delete();
        exp_cnt  = 0;
        exp_addr = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.r_valid !== 1'b0 || bus.b_valid !== 1'b0) seen = 1'b1;
        end
        check("no_resp_after_rst", seen, 0);
        check("post_rst_err_cnt", err_cnt, 0);
        check("post_rst_err_irq", err_irq, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_err_slv.md
AXI_ERR_SLV -- requirements
Module: axi_err_slv

Interface
REQ-001 SHALL have parameter AxiAddrWidth, default 64, AXI address width.
REQ-002 SHALL have parameter AxiDataWidth, default 64, AXI data width.
REQ-003 SHALL have parameter AxiIdWidth, default 4, AXI ID width.
REQ-004 SHALL have parameter AxiUserWidth, default 1, AXI user width.
REQ-005 SHALL have parameter RespCode, default 2'b10 (SLVERR), the B and R response code.
REQ-006 SHALL have parameter RespData, default 64'hdeadbeef, the R data value, zero-extended or truncated to AxiDataWidth.
REQ-007 SHALL have parameter MaxTrans, default 4, the outstanding AW and AR FIFO depth, minimum 1.
REQ-008 SHALL have parameter CntWidth, default 16, the error counter width.
REQ-009 SHALL have port clk_i, input, 1, the single clock; all logic is rising-edge.
REQ-010 SHALL have port rst_i, input, 1, the reset, asynchronous and active-high.
REQ-011 SHALL have port slave, AXI_BUS.Slave interface port, with the parameter widths above; it is a full AXI4 slave.
REQ-012 SHALL have port err_cnt_o, output, CntWidth, the count of completed erroneous transactions.
REQ-013 SHALL have port err_addr_o, output, AxiAddrWidth, the address of the most recently accepted AW or AR.
REQ-014 SHALL have port err_irq_o, output, 1, a one-cycle pulse per completed transaction.

Function
REQ-015 SHALL push {aw_id} into a MaxTrans-deep write FIFO on each AW handshake; aw_ready = write FIFO not full; no same-cycle full pass-through.
REQ-016 SHALL push {ar_id, ar_len} into a MaxTrans-deep read FIFO on each AR handshake; ar_ready = read FIFO not full.
REQ-017 SHALL implement write FSM W_IDLE -> W_DATA (FIFO non-empty) -> W_RESP (handshake with w_last=1) -> W_IDLE (B handshake, pop FIFO).
REQ-018 SHALL drive w_ready=1 only in W_DATA; W beats presented before their AW SHALL be stalled, never dropped.
REQ-019 SHALL drive b_valid=1 only in W_RESP, with b_id = FIFO head ID, b_resp = RespCode, b_user = 0; first b_valid is one cycle after the last W handshake.
REQ-020 SHALL hold b_valid and b_id stable until b_ready.
REQ-021 SHALL implement read FSM R_IDLE -> R_DATA (FIFO non-empty; load a beat counter with ar_len) -> R_IDLE (handshake on the final beat, pop FIFO).
REQ-022 SHALL in R_DATA drive r_valid=1, r_id = head ID, r_data = RespData, r_resp = RespCode, r_user = 0, and r_last=1 exactly on beat ar_len+1 (len 255 gives 256 beats); the counter SHALL decrement per R handshake.
REQ-023 SHALL produce the first r_valid no earlier than one cycle after the AR handshake and hold all R fields stable while r_valid && !r_ready.
REQ-024 SHALL run the read and write paths independently; simultaneous AW, AR, W, B and R handshakes in one cycle are all legal.
REQ-025 SHALL accept a push and a pop on a full FIFO in the same cycle with the occupancy unchanged; aw_ready/ar_ready stay 0 that cycle.
REQ-026 SHALL respond in acceptance order per direction, regardless of ID.

Reset
REQ-027 SHALL on rst_i=1 asynchronously empty both FIFOs, set both FSMs to IDLE, and force aw_ready, ar_ready, w_ready, b_valid, r_valid, err_cnt_o, err_addr_o and err_irq_o to 0.
REQ-028 SHALL, on reset mid-burst, abandon in-flight transactions without emitting a response after deassertion.

Configuration
REQ-029 SHALL honour the macro AXI_ERR_SLV_CNT_EN. When it is defined, err_cnt_o SHALL increment, saturating at all-ones, on each B handshake and each final-R handshake (+2 when both occur in the same cycle), err_addr_o SHALL capture aw_addr or ar_addr at handshake (AR wins on a tie), and err_irq_o SHALL pulse. When it is undefined, these three outputs SHALL be tied to 0 and no counter or capture flops SHALL exist.

Verification
REQ-030 Single write: AW id=3, then one W beat with last=1 -> B with id=3 and resp=2'b10 one cycle after the W handshake; err_cnt_o=1 (with the macro).
REQ-031 Read burst: AR id=5, len=7, r_ready=1 -> 8 R beats with data 'hdeadbeef, id=5, and r_last only on beat 8.
REQ-032 Backpressure: MaxTrans=2, 3 back-to-back AWs with no W -> the third AW stalls with aw_ready=0; after W data and B for the first, the third is accepted and B IDs come out in order.
REQ-033 W before AW: a W beat is presented 5 cycles before its AW -> w_ready=0 until the AW is accepted, then the beat completes and B is returned.
REQ-034 Reset mid-burst: AR len=15, rst_i asserted after beat 4 -> r_valid drops to 0 asynchronously; after reset, no further R beats occur and err_cnt_o=0.
REQ-035 Counter saturation: CntWidth=2, 5 writes -> err_cnt_o stays at 3; without AXI_ERR_SLV_CNT_EN -> err_cnt_o, err_addr_o and err_irq_o stay at 0.
